// File: rtl/exhaustive_sweep_capture.sv
// exhaustive_sweep_capture: walks all 2^IN_W input vectors, settles, captures responses over valid/ready and folds them into a MISR
module exhaustive_sweep_capture #(
  parameter int          IN_W   = 5,
  parameter int          OUT_W  = 1,
  parameter int          SETTLE = 1,
  parameter int          MISR_W = 16,
  parameter logic [31:0] POLY   = 32'h1021
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  output logic [IN_W-1:0]   vec_out,
  input  logic [OUT_W-1:0]  dut_resp,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [IN_W-1:0]   cap_vec,
  output logic [OUT_W-1:0]  cap_resp,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [IN_W:0] LAST = {1'b0, {IN_W{1'b1}}};
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;
  state_t state_q, state_d;
  logic [IN_W:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0] vec_q, vec_d, cap_vec_q, cap_vec_d;
  logic [OUT_W-1:0] cap_resp_q, cap_resp_d;
  logic [MISR_W-1:0] sig_q, sig_d, misr;
  logic mode_q, mode_d;
  function automatic logic [IN_W-1:0] enc(input logic [IN_W-1:0] i, input logic g);
    return g ? i ^ (i >> 1) : i;
  endfunction
  assign misr = (sig_q << 1) ^ (sig_q[MISR_W-1] ? POLY[MISR_W-1:0] : '0) ^ MISR_W'(cap_resp_q);
  assign vec_out = vec_q;
  assign cap_vec = cap_vec_q;
  assign cap_resp = cap_resp_q;
  assign signature = sig_q;
  assign cap_valid = state_q == S_CAPTURE;
  assign busy = state_q == S_SETTLE || state_q == S_CAPTURE;
  assign done = state_q == S_DONE;
  // next-state: start/settle/capture sequencing, abort forces IDLE without touching the MISR
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    vec_d = vec_q;
    cap_vec_d = cap_vec_q;
    cap_resp_d = cap_resp_q;
    sig_d = sig_q;
    mode_d = mode_q;
    if (abort) state_d = S_IDLE;
    else case (state_q)
      S_IDLE, S_DONE: if (start) begin
        idx_d = '0;
        sig_d = '0;
        mode_d = mode;
        cnt_d = CW'(SETTLE - 1);
        vec_d = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: if (cnt_q == '0) begin
        cap_resp_d = dut_resp;
        cap_vec_d = vec_q;
        state_d = S_CAPTURE;
      end else cnt_d = cnt_q - CW'(1);
      S_CAPTURE: if (cap_ready) begin
        sig_d = misr;
        if (idx_q == LAST) state_d = S_DONE;
        else begin
          idx_d = idx_q + (IN_W+1)'(1);
          vec_d = enc(idx_q[IN_W-1:0] + IN_W'(1), mode_q);
          cnt_d = CW'(SETTLE - 1);
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state register with synchronous reset
  always_ff @(posedge CK) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      vec_q <= '0;
      cap_vec_q <= '0;
      cap_resp_q <= '0;
      sig_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      cap_vec_q <= cap_vec_d;
      cap_resp_q <= cap_resp_d;
      sig_q <= sig_d;
      mode_q <= mode_d;
    end
  end
endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// tb_exhaustive_sweep_capture: self-checking bench against a plain-arithmetic sweep/MISR model
module tb_exhaustive_sweep_capture;
  localparam int IW = 4, OW = 3, ST = 2, N = 16;
  logic CK = 0, reset = 1, start = 0, abort = 0, mode = 0, cap_ready = 0;
  logic [IW-1:0] vec_out, cap_vec;
  logic [OW-1:0] dut_resp, cap_resp, salt = 0;
  logic cap_valid, busy, done;
  logic [15:0] signature;
  logic start1 = 0, resp1 = 0, ready1 = 1, abort1 = 0, mode1 = 0;
  logic vec1, cv1, cvec1, cresp1, busy1, done1;
  logic [15:0] sig1;
  int n_cmp = 0, n_bad = 0;
  logic [IW-1:0] exp_v [N];
  logic [OW-1:0] exp_r [N];
  logic [15:0] exp_s [N+1];
  logic [IW-1:0] cap_log [N];
  typedef struct {logic m; int pct; logic [OW-1:0] s;} sweep_t;
  typedef struct {logic r; logic [15:0] first; logic [15:0] fin;} seed_t;
  sweep_t sw [5];
  seed_t sd [2];
  logic [IW-1:0] gray_tab [N];
  always #5 CK = ~CK;
  function automatic logic [OW-1:0] stub(input logic [IW-1:0] v, input logic [OW-1:0] s);
    return OW'(v * 5) ^ s;
  endfunction
  assign dut_resp = stub(vec_out, salt);
  exhaustive_sweep_capture #(.IN_W(IW), .OUT_W(OW), .SETTLE(ST), .MISR_W(16), .POLY(32'h1021)) dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .mode(mode), .vec_out(vec_out),
    .dut_resp(dut_resp), .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_vec(cap_vec),
    .cap_resp(cap_resp), .busy(busy), .done(done), .signature(signature));
  exhaustive_sweep_capture #(.IN_W(1), .OUT_W(1), .SETTLE(1), .MISR_W(16), .POLY(32'h1021)) u1 (
    .CK(CK), .reset(reset), .start(start1), .abort(abort1), .mode(mode1), .vec_out(vec1),
    .dut_resp(resp1), .cap_valid(cv1), .cap_ready(ready1), .cap_vec(cvec1),
    .cap_resp(cresp1), .busy(busy1), .done(done1), .signature(sig1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [OW-1:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, r};
  endfunction
  task automatic build(input logic m, input logic [OW-1:0] s);
    exp_s[0] = '0;
    for (int i = 0; i < N; i++) begin
      exp_v[i] = m ? IW'(i ^ (i >> 1)) : IW'(i);
      exp_r[i] = stub(exp_v[i], s);
      exp_s[i+1] = misr_step(exp_s[i], exp_r[i]);
    end
  endtask
  task automatic run_sweep(input logic m, input int pct, input logic [OW-1:0] s, output logic [15:0] fin);
    int k, cyc;
    logic stall;
    logic [IW-1:0] hv;
    logic [OW-1:0] hr;
    salt = s;
    build(m, s);
    start = 1;
    mode = m;
    @(negedge CK);
    start = 0;
    mode = 1'($urandom_range(1));
    chk("start_done_clr", done, 0);
    chk("start_sig_clr", signature, 0);
    chk("start_vec0", vec_out, exp_v[0]);
    chk("start_busy", busy, 1);
    k = 0;
    cyc = 0;
    stall = 0;
    hv = '0;
    hr = '0;
    while (!done && cyc < 2000) begin
      chk("sig_run", signature, exp_s[k]);
      if (cap_valid) begin
        if (stall) begin
          chk("stall_vec", cap_vec, hv);
          chk("stall_resp", cap_resp, hr);
        end
        chk("vec_hold", vec_out, cap_vec);
        cap_ready = $urandom_range(99) < pct;
        if (cap_ready) begin
          if (k < N) begin
            chk("cap_vec", cap_vec, exp_v[k]);
            chk("cap_resp", cap_resp, exp_r[k]);
            cap_log[k] = cap_vec;
          end else chk("extra_cap", k, N - 1);
          k++;
          stall = 0;
        end else begin
          stall = 1;
          hv = cap_vec;
          hr = cap_resp;
        end
      end else cap_ready = 1'($urandom_range(1));
      start = busy && $urandom_range(7) == 0;
      @(negedge CK);
      cyc++;
    end
    start = 0;
    cap_ready = 0;
    chk("done", done, 1);
    chk("n_caps", k, N);
    chk("final_sig", signature, exp_s[N]);
    if (pct == 100) chk("done_cycle", cyc, N * (ST + 1));
    fin = signature;
    repeat (4) begin
      cap_ready = 1'($urandom_range(1));
      @(negedge CK);
      chk("done_frozen_sig", signature, fin);
      chk("done_held", done, 1);
      chk("done_no_valid", cap_valid, 0);
    end
  endtask
  initial begin
    logic [15:0] fin, fin_ref;
    int hs, cyc;
    logic chkd;
    sw[0] = '{1'b0, 100, 3'd5};
    sw[1] = '{1'b0, 40, 3'd5};
    sw[2] = '{1'b1, 100, 3'd2};
    sw[3] = '{1'b1, 60, 3'd6};
    sw[4] = '{1'b0, 100, 3'd1};
    sd[0] = '{1'b1, 16'd1, 16'd3};
    sd[1] = '{1'b0, 16'd0, 16'd0};
    gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hc, 4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8};
    fin_ref = '0;
    repeat (3) @(negedge CK);
    chk("rst_vec", vec_out, 0);
    chk("rst_valid", cap_valid, 0);
    chk("rst_cvec", cap_vec, 0);
    chk("rst_cresp", cap_resp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 0);
    reset = 0;
    @(negedge CK);
    for (int t = 0; t < 2; t++) begin
      resp1 = sd[t].r;
      start1 = 1;
      @(negedge CK);
      start1 = 0;
      hs = 0;
      chkd = 0;
      cyc = 0;
      while (!done1 && cyc < 50) begin
        if (hs == 1 && !chkd) begin
          chk("seed_first_sig", sig1, sd[t].first);
          chkd = 1;
        end
        if (cv1) hs++;
        @(negedge CK);
        cyc++;
      end
      chk("seed_done", done1, 1);
      chk("seed_caps", hs, 2);
      chk("seed_cycles", cyc, 4);
      chk("seed_final_sig", sig1, sd[t].fin);
    end
    for (int t = 0; t < 5; t++) begin
      run_sweep(sw[t].m, sw[t].pct, sw[t].s, fin);
      if (t == 0) fin_ref = fin;
      if (t == 1) chk("backpressure_sig", fin, fin_ref);
      if (sw[t].m)
        for (int i = 0; i < N; i++) begin
          chk("gray_order", cap_log[i], gray_tab[i]);
          if (i > 0) chk("gray_one_bit", $countones(cap_log[i] ^ cap_log[i-1]), 1);
        end
    end
    salt = 3'd3;
    build(1'b0, 3'd3);
    start = 1;
    mode = 0;
    @(negedge CK);
    start = 0;
    cyc = 0;
    while (!(cap_valid && cap_vec == 4'd10) && cyc < 200) begin
      cap_ready = 1;
      @(negedge CK);
      cyc++;
    end
    chk("abort_reached_vec10", cap_vec, 10);
    abort = 1;
    start = 1;
    cap_ready = 1;
    @(negedge CK);
    abort = 0;
    start = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", cap_valid, 0);
    chk("abort_sig_kept", signature, exp_s[10]);
    repeat (5) begin
      @(negedge CK);
      chk("abort_idle_valid", cap_valid, 0);
      chk("abort_idle_sig", signature, exp_s[10]);
    end
    run_sweep(1'b0, 70, 3'd3, fin);
    start = 1;
    mode = 1;
    @(negedge CK);
    start = 0;
    cyc = 0;
    while (!cap_valid && cyc < 50) begin
      @(negedge CK);
      cyc++;
    end
    chk("reset_in_capture", cap_valid, 1);
    reset = 1;
    cap_ready = 1;
    @(negedge CK);
    reset = 0;
    cap_ready = 0;
    chk("rr_vec", vec_out, 0);
    chk("rr_valid", cap_valid, 0);
    chk("rr_cvec", cap_vec, 0);
    chk("rr_cresp", cap_resp, 0);
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_sig", signature, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
